// File: rtl/shell_pkg.sv
// Shared types and constants for the shell (projectile) controller.
// The optional gravity feature is selected with SHELL_GRAVITY_EN.
package shell_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLIGHT  = 2'd1,
    EXPLODE = 2'd2
  } shell_state_t;

  localparam int SCR_X_MAX = 639;
  localparam int SCR_Y_MAX = 479;
  localparam int RESET_X   = 320;
  localparam int RESET_Y   = 240;

  // Limit the aim value to +/-lim before it becomes the launch vertical speed.
  function automatic logic signed [9:0] clamp_vy(input logic signed [9:0] y,
                                                 input int lim);
    logic signed [9:0] l;
    l = 10'(lim);
    if (y > l)       return l;
    else if (y < -l) return -l;
    else             return y;
  endfunction

endpackage

// File: rtl/shell_if.sv
// Tank-to-shell bundle: launch request/aim in, shell position/status out.
// Launch is a level-sampled request (no ready): shoot is acted on only in IDLE.
interface shell_if;
  import shell_pkg::*;

  logic         shoot;
  logic [9:0]   TankX;
  logic [9:0]   TankY;
  logic [1:0]   Direction;
  logic [9:0]   y_component;
  logic [9:0]   ShellX;
  logic [9:0]   ShellY;
  logic [9:0]   ShellS;
  logic         shell_active;
  logic         exploding;
  logic         shell_done;
  shell_state_t state;

  modport master (
    output shoot, TankX, TankY, Direction, y_component,
    input  ShellX, ShellY, ShellS, shell_active, exploding, shell_done, state
  );

  modport slave (
    input  shoot, TankX, TankY, Direction, y_component,
    output ShellX, ShellY, ShellS, shell_active, exploding, shell_done, state
  );
endinterface

// File: rtl/frame_down_counter.sv
// Loadable down-counter that stops at zero and flags it; times the explosion.
module frame_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    count <= '0;
    else if (load)              count <= load_val;
    else if (dec && count != 0) count <= count - 1'b1;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/shell_ctrl.sv
// Single-shell projectile controller: IDLE -> FLIGHT -> EXPLODE, one step per frame.
// Define SHELL_GRAVITY_EN to add gravity (vy += 1 every GRAV_DIV frames).
module shell_ctrl
  import shell_pkg::*;
#(
  parameter int SHELL_X_SPEED  = 4,
  parameter int SHELL_VY_MAX   = 15,
  parameter int GRAV_DIV       = 4,
  parameter int EXPLODE_FRAMES = 16,
  parameter int SHELL_SIZE     = 2
) (
  input  logic    frame_clk,
  input  logic    Reset,
  shell_if.slave  bus
);
  localparam int CW = (EXPLODE_FRAMES > 2) ? $clog2(EXPLODE_FRAMES) : 1;

  shell_state_t      state;
  logic [9:0]        shell_x, shell_y, shell_s;
  logic              active, expl, done;
  logic              face;
  logic signed [9:0] vx, vy;

  logic              face_next;
  logic signed [11:0] nx, ny;
  logic              oob;
  logic [9:0]        x_sat, y_sat;
  logic              cnt_load, cnt_dec, cnt_zero;

  always_comb begin
    face_next = face;
    if (bus.Direction == 2'd0)      face_next = 1'b0;
    else if (bus.Direction == 2'd1) face_next = 1'b1;
  end

  // Next position in signed 12-bit so steps past either edge are visible.
  always_comb begin
    nx = $signed({2'b00, shell_x}) + $signed({{2{vx[9]}}, vx});
    ny = $signed({2'b00, shell_y}) + $signed({{2{vy[9]}}, vy});
    oob = nx[11] || (nx > 12'(SCR_X_MAX)) || ny[11] || (ny > 12'(SCR_Y_MAX));
    x_sat = nx[9:0];
    if (nx[11])                   x_sat = '0;
    else if (nx > 12'(SCR_X_MAX)) x_sat = 10'(SCR_X_MAX);
    y_sat = ny[9:0];
    if (ny[11])                   y_sat = '0;
    else if (ny > 12'(SCR_Y_MAX)) y_sat = 10'(SCR_Y_MAX);
  end

  assign cnt_load = (state == FLIGHT) && oob;
  assign cnt_dec  = (state == EXPLODE);

  frame_down_counter #(.W(CW)) u_explode_cnt (
    .clk      (frame_clk),
    .rst      (Reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (CW'(EXPLODE_FRAMES - 1)),
    .zero     (cnt_zero)
  );

`ifdef SHELL_GRAVITY_EN
  localparam int GW = (GRAV_DIV > 2) ? $clog2(GRAV_DIV) : 1;
  logic [GW-1:0]     grav_cnt;
  logic              grav_tick;
  logic signed [9:0] vy_grav;
  assign grav_tick = (grav_cnt == GW'(GRAV_DIV - 1));
  // vy saturates at +511 rather than wrapping negative.
  assign vy_grav   = (vy == 10'sd511) ? vy : vy + 10'sd1;
`endif

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      shell_x  <= 10'(RESET_X);
      shell_y  <= 10'(RESET_Y);
      shell_s  <= '0;
      active   <= 1'b0;
      expl     <= 1'b0;
      done     <= 1'b0;
      face     <= 1'b1;
      vx       <= '0;
      vy       <= '0;
`ifdef SHELL_GRAVITY_EN
      grav_cnt <= '0;
`endif
    end else begin
      face <= face_next;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.shoot) begin
            shell_x <= bus.TankX;
            shell_y <= bus.TankY;
            vx      <= face_next ? 10'(SHELL_X_SPEED) : 10'(-SHELL_X_SPEED);
            vy      <= -clamp_vy($signed(bus.y_component), SHELL_VY_MAX);
            shell_s <= 10'(SHELL_SIZE);
            active  <= 1'b1;
            state   <= FLIGHT;
`ifdef SHELL_GRAVITY_EN
            grav_cnt <= '0;
`endif
          end
        end
        FLIGHT: begin
          // Saturated coordinates equal nx/ny whenever the step stays on screen.
          shell_x <= x_sat;
          shell_y <= y_sat;
`ifdef SHELL_GRAVITY_EN
          if (grav_tick) begin
            grav_cnt <= '0;
            vy       <= vy_grav;
          end else begin
            grav_cnt <= grav_cnt + 1'b1;
          end
`endif
          if (oob) begin
            state   <= EXPLODE;
            active  <= 1'b0;
            expl    <= 1'b1;
            shell_s <= 10'(4 * SHELL_SIZE);
          end
        end
        EXPLODE: begin
          if (cnt_zero) begin
            state   <= IDLE;
            expl    <= 1'b0;
            done    <= 1'b1;
            shell_s <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ShellX       = shell_x;
  assign bus.ShellY       = shell_y;
  assign bus.ShellS       = shell_s;
  assign bus.shell_active = active;
  assign bus.exploding    = expl;
  assign bus.shell_done   = done;
  assign bus.state        = state;
endmodule
